// File: rtl/bit_serial_alu_if.sv
// Handshake and operand/result bundle for the bit-serial ALU.
interface bit_serial_alu_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ainvert;
  logic             bnegate;
  logic [1:0]       op;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             carryOut;
  logic             overflow;
  logic             zero;

  modport master (
    output start, a, b, ainvert, bnegate, op,
    input  busy, done, result, carryOut, overflow, zero
  );

  modport slave (
    input  start, a, b, ainvert, bnegate, op,
    output busy, done, result, carryOut, overflow, zero
  );
endinterface

// File: rtl/bit_serial_alu.sv
// Bit-serial ALU: one operand bit per clock, LSB first, AND/OR/ADD-SUB/SLT
// with ainvert/bnegate control; start/done handshake, results held until next DONE.
module bit_serial_alu #(
  parameter int WIDTH = 8
) (
  input logic           clk,
  input logic           rst,
  bit_serial_alu_if.slave bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, SLT_FIX, DONE} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q, sh_q, sh_d, res_q;
  logic             ainv_q, bneg_q;
  logic [1:0]       op_q;
  logic [CW-1:0]    cnt_q;
  logic             carry_q, cout_q, ovf_q, set_q;
  logic             co_q, ov_q, zero_q;
  logic             accept, last, arith;
  logic             ai, bi, sum, cnew, rbit;
  logic             co_d, ov_d;
  logic             busy, done;

  assign accept = bus.start && (state_q == IDLE || state_q == DONE);
  assign last   = (cnt_q == CW'(WIDTH - 1));
  assign arith  = op_q[1];

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = RUN;
      RUN:     if (last) state_d = (op_q == 2'd3) ? SLT_FIX : DONE;
      SLT_FIX: state_d = DONE;
      DONE:    state_d = bus.start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == RUN) || (state_q == SLT_FIX);
    done = (state_q == DONE);
  end

  always_comb begin
    ai   = a_q[cnt_q] ^ ainv_q;
    bi   = b_q[cnt_q] ^ bneg_q;
    sum  = ai ^ bi ^ carry_q;
    cnew = (ai & bi) | (ai & carry_q) | (bi & carry_q);
    case (op_q)
      2'd0:    rbit = ai & bi;
      2'd1:    rbit = ai | bi;
      2'd2:    rbit = sum;
      default: rbit = 1'b0;
    endcase
    sh_d = sh_q;
    if (accept)                  sh_d = '0;
    else if (state_q == RUN)     sh_d = {rbit, sh_q[WIDTH-1:1]};
    else if (state_q == SLT_FIX) sh_d = WIDTH'(set_q);
    // Flags come straight from the last bit step when DONE follows RUN directly
    co_d = (state_q == RUN) ? (arith & cnew) : cout_q;
    ov_d = (state_q == RUN) ? (arith & (carry_q ^ cnew)) : ovf_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      ainv_q  <= 1'b0;
      bneg_q  <= 1'b0;
      op_q    <= '0;
      sh_q    <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      set_q   <= 1'b0;
      res_q   <= '0;
      co_q    <= 1'b0;
      ov_q    <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      sh_q <= sh_d;
      if (accept) begin
        a_q     <= bus.a;
        b_q     <= bus.b;
        ainv_q  <= bus.ainvert;
        bneg_q  <= bus.bnegate;
        op_q    <= bus.op;
        carry_q <= bus.bnegate;
        cnt_q   <= '0;
      end else if (state_q == RUN) begin
        carry_q <= cnew;
        cnt_q   <= cnt_q + CW'(1);
        if (last) begin
          cout_q <= arith & cnew;
          ovf_q  <= arith & (carry_q ^ cnew);
          set_q  <= sum ^ (carry_q ^ cnew);
        end
      end
      if (state_d == DONE) begin
        res_q  <= sh_d;
        zero_q <= (sh_d == '0);
        co_q   <= co_d;
        ov_q   <= ov_d;
      end
    end
  end

  assign bus.busy     = busy;
  assign bus.done     = done;
  assign bus.result   = res_q;
  assign bus.carryOut = co_q;
  assign bus.overflow = ov_q;
  assign bus.zero     = zero_q;
endmodule

// File: tb/tb_bit_serial_alu.sv
// Self-checking bench for bit_serial_alu: vector table plus handshake corner sequences.
module tb_bit_serial_alu;
  localparam int W = 8;

  typedef struct {
    logic [1:0]   op;
    logic         ainv;
    logic         bneg;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic         co;
    logic         ov;
    logic         z;
  } vec_t;

  typedef struct {
    logic [W-1:0] res;
    logic         co;
    logic         ov;
    logic         z;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bit_serial_alu_if #(.WIDTH(W)) bus ();
  bit_serial_alu #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  int   checks   = 0;
  int   failures = 0;
  exp_t sbq[$];
  exp_t mon_e;
  vec_t tbl[15];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.a       = v.a;
    bus.b       = v.b;
    bus.ainvert = v.ainv;
    bus.bnegate = v.bneg;
    bus.op      = v.op;
  endtask

  task automatic push(input vec_t v);
    exp_t e;
    e.res = v.res; e.co = v.co; e.ov = v.ov; e.z = v.z;
    sbq.push_back(e);
  endtask

  task automatic start_op(input vec_t v, input bit expect_done);
    @(negedge clk);
    drive(v);
    bus.start = 1'b1;
    @(posedge clk);
    if (expect_done) push(v);
    #1;
    bus.start = 1'b0;
    chk("busy_rise", bus.busy, 1);
  endtask

  // Counts edges after the start edge until done; optionally re-pulses start mid-run.
  task automatic wait_done(input int lat, input string nm, input bit inject);
    int n = 0;
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk);
      #1;
      if (inject && k == 3) begin
        bus.start = 1'b1; bus.a = 8'hFF; bus.b = 8'hFF; bus.op = 2'd1;
      end
      if (inject && k == 4) bus.start = 1'b0;
      if (bus.done === 1'b1) begin
        n = k;
        break;
      end
    end
    chk({nm, "_latency"}, n, lat);
  endtask

  always @(negedge clk) begin
    if (bus.done === 1'b1) begin
      chk("done_expected", (sbq.size() > 0), 1);
      chk("busy_at_done", bus.busy, 0);
      if (sbq.size() > 0) begin
        mon_e = sbq.pop_front();
        chk("result",   bus.result,   mon_e.res);
        chk("carryOut", bus.carryOut, mon_e.co);
        chk("overflow", bus.overflow, mon_e.ov);
        chk("zero",     bus.zero,     mon_e.z);
      end
    end
  end

  initial begin
    tbl[0]  = '{op: 2'd0, ainv: 0, bneg: 0, a: 8'hF0, b: 8'h3C, res: 8'h30, co: 0, ov: 0, z: 0};
    tbl[1]  = '{op: 2'd0, ainv: 1, bneg: 1, a: 8'h0F, b: 8'h30, res: 8'hC0, co: 0, ov: 0, z: 0};
    tbl[2]  = '{op: 2'd1, ainv: 0, bneg: 0, a: 8'h00, b: 8'h00, res: 8'h00, co: 0, ov: 0, z: 1};
    tbl[3]  = '{op: 2'd2, ainv: 0, bneg: 0, a: 8'hFF, b: 8'h01, res: 8'h00, co: 1, ov: 0, z: 1};
    tbl[4]  = '{op: 2'd2, ainv: 0, bneg: 1, a: 8'h05, b: 8'h07, res: 8'hFE, co: 0, ov: 0, z: 0};
    tbl[5]  = '{op: 2'd2, ainv: 0, bneg: 1, a: 8'h7F, b: 8'hFF, res: 8'h80, co: 0, ov: 1, z: 0};
    tbl[6]  = '{op: 2'd3, ainv: 0, bneg: 1, a: 8'h80, b: 8'h01, res: 8'h01, co: 1, ov: 1, z: 0};
    tbl[7]  = '{op: 2'd3, ainv: 0, bneg: 1, a: 8'h7F, b: 8'h80, res: 8'h00, co: 0, ov: 1, z: 1};
    tbl[8]  = '{op: 2'd3, ainv: 0, bneg: 1, a: 8'h03, b: 8'h03, res: 8'h00, co: 1, ov: 0, z: 1};
    tbl[9]  = '{op: 2'd1, ainv: 0, bneg: 0, a: 8'hA5, b: 8'h0F, res: 8'hAF, co: 0, ov: 0, z: 0};
    tbl[10] = '{op: 2'd2, ainv: 0, bneg: 0, a: 8'h12, b: 8'h34, res: 8'h46, co: 0, ov: 0, z: 0};
    tbl[11] = '{op: 2'd2, ainv: 0, bneg: 0, a: 8'h80, b: 8'h80, res: 8'h00, co: 1, ov: 1, z: 1};
    tbl[12] = '{op: 2'd0, ainv: 1, bneg: 0, a: 8'h0F, b: 8'hFF, res: 8'hF0, co: 0, ov: 0, z: 0};
    tbl[13] = '{op: 2'd3, ainv: 0, bneg: 1, a: 8'h01, b: 8'h80, res: 8'h00, co: 0, ov: 1, z: 1};
    tbl[14] = '{op: 2'd3, ainv: 0, bneg: 1, a: 8'hFE, b: 8'h05, res: 8'h01, co: 1, ov: 0, z: 0};

    rst = 1'b1;
    bus.start = 1'b0; bus.a = '0; bus.b = '0;
    bus.ainvert = 1'b0; bus.bnegate = 1'b0; bus.op = 2'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_result", bus.result, 0);
    chk("rst_carryOut", bus.carryOut, 0);
    chk("rst_overflow", bus.overflow, 0);
    chk("rst_zero", bus.zero, 0);

    // start coincident with reset must be dropped
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    chk("start_in_rst_busy", bus.busy, 0);
    @(negedge clk);
    rst = 1'b0;
    bus.start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("idle_busy", bus.busy, 0);

    for (int i = 0; i < 15; i++) begin
      start_op(tbl[i], 1'b1);
      wait_done((tbl[i].op == 2'd3) ? W + 1 : W, "table", 1'b0);
    end

    // start held high through DONE: second op begins with no IDLE cycle
    @(negedge clk);
    drive(tbl[4]);
    bus.start = 1'b1;
    @(posedge clk);
    push(tbl[4]);
    #1;
    drive(tbl[6]);
    wait_done(W, "held_first", 1'b0);
    @(posedge clk);
    push(tbl[6]);
    #1;
    bus.start = 1'b0;
    chk("b2b_busy", bus.busy, 1);
    wait_done(W + 1, "held_second", 1'b0);

    // start re-pulsed with new operands mid-run is ignored
    start_op(tbl[10], 1'b1);
    wait_done(W, "midrun", 1'b1);
    repeat (3) @(posedge clk);
    #1;
    chk("idle_after_midrun", bus.busy, 0);

    // reset at bit 4 aborts with no done pulse
    start_op(tbl[9], 1'b0);
    repeat (4) @(posedge clk);
    #1;
    chk("held_result_during_run", bus.result, 8'h46);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_busy", bus.busy, 0);
    chk("abort_result", bus.result, 0);
    chk("abort_done", bus.done, 0);
    rst = 1'b0;
    repeat (14) @(posedge clk);
    #1;
    chk("abort_idle", bus.busy, 0);
    chk("scoreboard_drained", sbq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/bit_serial_alu.md
# bit_serial_alu

Bit-serial WIDTH-bit ALU that evaluates one operand bit per clock, LSB first, using the same single-bit function set as the 1-bit ALU slice: AND, OR, ADD/SUB and SLT, with ainvert/bnegate operand control. It sits beside the 1-bit ALU as its sequential driver. A start/done handshake latches the operands and the opcode, steps a shift-register datapath through all bits, and presents the WIDTH-bit result and the flags. It serves as the small-area alternative to a ripple array of slices.

## Interface
- WIDTH, 8, operand/result width in bits (≥2)
- clk  input  1  rising-edge clock; the only clock in the block
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled only when busy=0
- a  input  WIDTH  operand A (in1 of each slice step)
- b  input  WIDTH  operand B (in2 of each slice step)
- ainvert  input  1  invert A bits before the function
- bnegate  input  1  invert B bits and force initial carryIn=1
- op  input  2  0=AND, 1=OR, 2=ADD, 3=SLT
- busy  output  1  high while RUN or SLT_FIX
- done  output  1  one-cycle pulse; result and flags are valid
- result  output  WIDTH  result; held until the next accepted start
- carryOut  output  1  carry out of the MSB for op 2/3; 0 for op 0/1
- overflow  output  1  signed overflow for op 2/3 (carry into MSB XOR carry out of MSB); 0 for op 0/1
- zero  output  1  result==0, registered with result

## Operation
- States: IDLE, RUN, SLT_FIX, DONE.
- IDLE/DONE with start=1:
  - Latch a, b, ainvert, bnegate and op.
  - Clear the result shift register.
  - Load carry flop = bnegate and bit counter = 0.
  - Go to RUN.
- RUN, each cycle, bit i = counter:
  - ai = a[i]^ainvert, bi = b[i]^bnegate.
  - op0: ai&bi. op1: ai|bi. op2/3: sum = ai^bi^carry, new carry = majority(ai,bi,carry).
  - Result bit: op3 writes 0 into bit i; op0/1/2 write the computed bit.
  - Result shifts right, with the new bit entering the MSB; after WIDTH shifts bit i sits at position i.
  - At i=WIDTH-1, register carryOut and overflow.
  - Op3 only: set = sumMSB XOR overflow, the overflow-corrected sign.
  - At i=WIDTH-1 go to SLT_FIX if op=3, else to DONE.
- SLT_FIX: result[0] = set, upper bits remain 0; go to DONE.
- DONE:
  - done=1 for exactly this cycle, zero updated.
  - Without start, go to IDLE.
  - With start, accept the new request immediately (back-to-back).
- start while busy=1 is ignored and not queued.
- Input changes while busy have no effect; all operands and controls are latched.
- SLT is meaningful only with bnegate=1. With bnegate=0, set is taken from a+b with no further checking.
- Arithmetic is modulo 2^WIDTH. SUB is a + ~b + 1, where carryOut=1 means no borrow.

## Timing
- Reset:
  - State IDLE.
  - busy=0, done=0, result=0, carryOut=0, overflow=0, zero=0.
  - Counter and carry cleared.
- rst is dominant over all other inputs in the same cycle.
- rst mid-operation aborts immediately: no done pulse, outputs take their reset values on the next edge.
- Let edge E be the edge that samples start.
  - busy rises after E.
  - op0–2: done is high in the cycle after edge E+WIDTH; busy falls at that edge.
  - op3: done is high after edge E+WIDTH+1.
- result, carryOut, overflow and zero change only at the edge that enters DONE, or at reset.
  - Between operations they hold their values.
  - At an accepted start the internal register clears, but the visible result keeps its previous value until DONE.
- A start held high continuously gives one operation per WIDTH+1 cycles for op0–2 and one per WIDTH+2 cycles for op3.

## Test plan
- WIDTH=8 in all scenarios.
- Reset then idle: all outputs 0, busy=0. Pulse start with rst=1 in the same cycle -> no operation, busy stays 0.
- AND and NOR forms:
  - op0, a=0xF0, b=0x3C -> result 0x30, carryOut=0, zero=0.
  - op0, ainvert=1, bnegate=1, a=0x0F, b=0x30 -> result 0xC0.
  - op1, a=0x00, b=0x00 -> result 0x00, zero=1.
- ADD:
  - op2, a=0xFF, b=0x01 -> result 0x00, carryOut=1, overflow=0, zero=1.
  - done arrives exactly 8 cycles after the start edge.
- SUB, op2 with bnegate=1:
  - a=0x05, b=0x07 -> result 0xFE, carryOut=0.
  - a=0x7F, b=0xFF -> result 0x80, overflow=1.
- SLT, op3 with bnegate=1; done arrives 9 cycles after the start edge:
  - a=0x80, b=0x01 -> result 0x01.
  - a=0x7F, b=0x80 -> result 0x00 (overflow correction).
  - a=0x03, b=0x03 -> result 0x00, zero=1.
- Handshake corners:
  - start re-pulsed with new operands mid-RUN -> ignored; the original result is delivered.
  - start held high through DONE -> the next operation starts with no IDLE cycle.
  - rst asserted at bit 4 -> busy=0 and result=0 after that edge; no done pulse.
